mole_hit_detect: RTL and testbench
==================================

MOLE_HIT_DETECT -- requirements
Module: mole_hit_detect

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive cycles a synchronized button level must differ from the debounced level before the debounced level changes; legal range 1..65535.
REQ-002 Parameter LOCKOUT_CYCLES, default 5000000, number of cycles press events are ignored after a hit or miss; legal range 1..2^24-1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn  input  4  raw asynchronous player buttons, one per hole, active-high.
REQ-006 mole_active  input  4  synchronous mask from mole generator; bit i high = mole showing in hole i.
REQ-007 game_en  input  1  synchronous enable; low = detection disabled.
REQ-008 hit  output  1  registered one-cycle pulse per valid whack; drives score counter increment input.
REQ-009 miss  output  1  registered one-cycle pulse per press on an empty hole.
REQ-010 hit_idx  output  2  hole index of last hit; valid while hit high, holds value otherwise.
REQ-011 whack_clear  output  4  registered one-hot one-cycle pulse to mole generator, same cycle as hit.

Function
REQ-012 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per button, a debounce counter SHALL increment each cycle the synchronized level differs from the debounced level and clear to 0 when equal; the debounced level SHALL toggle and its counter clear on the DEBOUNCE_CYCLES-th consecutive differing cycle.
REQ-014 A press event on bit i SHALL be debounced rising edge (debounced high, previous-cycle debounced low); falling edges SHALL produce no event.
REQ-015 FSM states: IDLE, ARMED, LOCKOUT.
REQ-016 IDLE: game_en high -> ARMED next cycle; press events discarded.
REQ-017 ARMED: press event(s) present -> outputs per REQ-018/019 registered at the same edge, FSM -> LOCKOUT with lockout counter loaded to 0.
REQ-018 If any press event bit coincides with mole_active, hit=1, hit_idx = lowest such index, whack_clear = one-hot of that index, miss=0.
REQ-019 Else if any press event, miss=1, hit=0, whack_clear=0.
REQ-020 Simultaneous presses in one cycle SHALL yield exactly one pulse (hit or miss), never both.
REQ-021 LOCKOUT: counter increments each cycle; -> ARMED after exactly LOCKOUT_CYCLES cycles in LOCKOUT; press events during LOCKOUT discarded (debouncers keep running).
REQ-022 game_en low in any state -> IDLE at next edge, lockout counter cleared; no pulse generated that cycle.
REQ-023 hit, miss, whack_clear SHALL be low in every cycle except a single registered pulse cycle.
REQ-024 Latency: with game_en high and FSM in ARMED, btn bit rising and held stable SHALL produce hit/miss high after exactly DEBOUNCE_CYCLES+3 rising edges (edge 1 = first edge sampling btn high).
REQ-025 Bounces shorter than DEBOUNCE_CYCLES cycles SHALL produce no event.

Reset
REQ-026 Synchronous reset SHALL set FSM to IDLE, synchronizers, debounced levels, debounce and lockout counters to 0, and hit, miss, whack_clear, hit_idx to 0.
REQ-027 Reset SHALL override every other input including mid-LOCKOUT and mid-debounce; a button held high across reset release SHALL produce one press event after debounce.

Verification (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8)
REQ-028 game_en=1, mole_active=4'b0100, btn[2] rises and holds -> hit pulse one cycle after edge 7, hit_idx=2, whack_clear=4'b0100, miss=0.
REQ-029 mole_active=4'b0000, btn[0] press -> miss one cycle, hit=0, whack_clear=0.
REQ-030 mole_active=4'b1010, btn[3] and btn[1] rise same cycle -> single hit, hit_idx=1, whack_clear=4'b0010.
REQ-031 btn[2] toggling every 2 cycles for 40 cycles -> no hit, no miss; second valid press 3 cycles after a hit -> ignored; press after 8 lockout cycles -> counted.
REQ-032 Reset asserted during LOCKOUT, and game_en dropped mid-debounce -> all outputs 0, FSM IDLE next edge, no pulse until game_en high and new debounced press.

Source files
------------

// File: rtl/mole_hit_detect.sv
// Whack-a-mole hit detector.
// Synchronizes and debounces four player buttons and turns debounced rising
// edges into press events. A three-state FSM (IDLE/ARMED/LOCKOUT) classifies
// each accepted press as a hit or a miss, then ignores presses for a lockout
// period.
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   btn[3:0]     raw asynchronous buttons, active-high, one per hole
//   mole_active  mask of holes currently showing a mole
//   game_en      detection enable; low forces IDLE
//   hit          one-cycle pulse per valid whack
//   miss         one-cycle pulse per press on an empty hole
//   hit_idx      index of the most recent hit, held between hits
//   whack_clear  one-hot clear to the mole generator, same cycle as hit
module mole_hit_detect #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned LOCKOUT_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [3:0] mole_active,
  input  logic       game_en,
  output logic       hit,
  output logic       miss,
  output logic [1:0] hit_idx,
  output logic [3:0] whack_clear
);

  localparam int unsigned NBTN = 4;
  localparam int unsigned DB_W = 16;
  localparam int unsigned LO_W = 24;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LO_W-1:0] LO_LAST = LO_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_LOCKOUT = 2'd2
  } state_e;

  logic [NBTN-1:0] sync1_q, sync2_q;
  logic [NBTN-1:0] deb_q, deb_d;
  logic [NBTN-1:0] deb_prev_q;
  logic [DB_W-1:0] db_cnt_q [NBTN];
  logic [DB_W-1:0] db_cnt_d [NBTN];

  state_e          state_q, state_d;
  logic [LO_W-1:0] lo_cnt_q, lo_cnt_d;
  logic            hit_q, hit_d;
  logic            miss_q, miss_d;
  logic [1:0]      hit_idx_q, hit_idx_d;
  logic [3:0]      whack_q, whack_d;

  logic [NBTN-1:0] press_c;
  logic [NBTN-1:0] hit_mask_c;
  logic [1:0]      first_idx_c;

  // Two-flop synchronizer and previous-debounced-level register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_prev_q <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
    end
  end

  // Debounce: count consecutive differing cycles, toggle on the last one.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NBTN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Press events are debounced rising edges only.
  assign press_c    = deb_q & ~deb_prev_q;
  assign hit_mask_c = press_c & mole_active;

  // Lowest-index hole among simultaneous hits.
  always_comb begin
    first_idx_c = 2'd0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (hit_mask_c[i]) first_idx_c = 2'(i);
    end
  end

  // FSM next state and registered pulse outputs.
  always_comb begin
    state_d   = state_q;
    lo_cnt_d  = lo_cnt_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    whack_d   = 4'b0000;
    hit_idx_d = hit_idx_q;
    if (!game_en) begin
      state_d  = S_IDLE;
      lo_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_ARMED;
          lo_cnt_d = '0;
        end
        S_ARMED: begin
          if (|press_c) begin
            state_d  = S_LOCKOUT;
            lo_cnt_d = '0;
            if (|hit_mask_c) begin
              hit_d     = 1'b1;
              hit_idx_d = first_idx_c;
              whack_d   = 4'b0001 << first_idx_c;
            end else begin
              miss_d = 1'b1;
            end
          end
        end
        S_LOCKOUT: begin
          if (lo_cnt_q == LO_LAST) begin
            state_d  = S_ARMED;
            lo_cnt_d = '0;
          end else begin
            lo_cnt_d = lo_cnt_q + LO_W'(1);
          end
        end
        default: begin
          state_d  = S_IDLE;
          lo_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lo_cnt_q  <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      hit_idx_q <= 2'd0;
      whack_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      lo_cnt_q  <= lo_cnt_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      hit_idx_q <= hit_idx_d;
      whack_q   <= whack_d;
    end
  end

  assign hit         = hit_q;
  assign miss        = miss_q;
  assign hit_idx     = hit_idx_q;
  assign whack_clear = whack_q;

endmodule

// File: tb/tb_mole_hit_detect.sv
// Directed bench for mole_hit_detect with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8.
// A held press produces its pulse 7 edges after the first edge sampling btn.
module tb_mole_hit_detect;

  localparam int unsigned DB = 4;
  localparam int unsigned LO = 8;
  localparam int unsigned LAT = DB + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] mole_active;
  logic       game_en;
  logic       hit;
  logic       miss;
  logic [1:0] hit_idx;
  logic [3:0] whack_clear;

  int total = 0;
  int bad   = 0;

  mole_hit_detect #(
    .DEBOUNCE_CYCLES(DB),
    .LOCKOUT_CYCLES (LO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .mole_active(mole_active),
    .game_en    (game_en),
    .hit        (hit),
    .miss       (miss),
    .hit_idx    (hit_idx),
    .whack_clear(whack_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, returning how many pulse cycles (hit or miss) occurred.
  task automatic run(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (hit || miss || (whack_clear != 4'b0000)) pulses++;
    end
  endtask

  // Hold a press and check the pulse lands exactly LAT edges later.
  task automatic press_expect(input string tag, input logic [3:0] b, input logic [3:0] mole,
                              input logic e_hit, input logic e_miss,
                              input logic [1:0] e_idx, input logic [3:0] e_wc);
    int p;
    mole_active = mole;
    btn = b;
    for (int c = 1; c <= int'(LAT); c++) begin
      tick();
      if (c < int'(LAT)) chk({tag, "_early"}, {30'd0, hit, miss}, 32'd0);
    end
    chk({tag, "_hit"},   {31'd0, hit},  {31'd0, e_hit});
    chk({tag, "_miss"},  {31'd0, miss}, {31'd0, e_miss});
    chk({tag, "_idx"},   {30'd0, hit_idx}, {30'd0, e_idx});
    chk({tag, "_wc"},    {28'd0, whack_clear}, {28'd0, e_wc});
    tick();
    chk({tag, "_after"}, {26'd0, hit, miss, whack_clear}, 32'd0);
    chk({tag, "_hold"},  {30'd0, hit_idx}, {30'd0, e_idx});
    btn = 4'b0000;
    run(20, p);
    chk({tag, "_settle"}, p, 32'd0);
  endtask

  initial begin
    int p;
    logic e;
    reset = 1'b1;
    btn = 4'b0000;
    mole_active = 4'b0000;
    game_en = 1'b0;
    tick(); tick(); tick();
    chk("rst_hit",  {31'd0, hit}, 32'd0);
    chk("rst_miss", {31'd0, miss}, 32'd0);
    chk("rst_idx",  {30'd0, hit_idx}, 32'd0);
    chk("rst_wc",   {28'd0, whack_clear}, 32'd0);
    reset = 1'b0;
    game_en = 1'b1;
    tick();

    press_expect("hit2",  4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2, 4'b0100);
    press_expect("miss0", 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000);
    press_expect("dual",  4'b1010, 4'b1010, 1'b1, 1'b0, 2'd1, 4'b0010);

    // Bouncing button never stays stable long enough.
    mole_active = 4'b0100;
    p = 0;
    for (int c = 0; c < 40; c++) begin
      btn[2] = ((c / 2) % 2) == 0;
      tick();
      if (hit || miss) p++;
    end
    chk("bounce", p, 32'd0);
    btn = 4'b0000;
    run(12, p);
    chk("bounce_settle", p, 32'd0);

    // Hit at 7, btn[3] event at 10 falls in lockout, btn[0] at 16 accepted.
    mole_active = 4'b1011;
    for (int c = 1; c <= 20; c++) begin
      btn[1] = 1'b1;
      btn[3] = (c >= 4);
      btn[0] = (c >= 10);
      tick();
      e = (c == 7) || (c == 16);
      chk($sformatf("lock_hit_c%0d", c), {31'd0, hit}, {31'd0, e});
      if (c == 7)  chk("lock_idx1", {30'd0, hit_idx}, 32'd1);
      if (c == 16) chk("lock_idx0", {30'd0, hit_idx}, 32'd0);
      if (c == 16) chk("lock_wc0", {28'd0, whack_clear}, 32'd1);
    end
    btn = 4'b0000;
    run(20, p);
    chk("lock_settle", p, 32'd0);

    // Reset mid-lockout; held button yields one event after reset release.
    mole_active = 4'b0100;
    btn = 4'b0100;
    for (int c = 0; c < int'(LAT); c++) tick();
    chk("pre_rst_hit", {31'd0, hit}, 32'd1);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("midrst_out", {28'd0, hit, miss, hit_idx}, 32'd0);
    chk("midrst_wc", {28'd0, whack_clear}, 32'd0);
    reset = 1'b0;
    for (int c = 1; c <= int'(LAT); c++) begin
      tick();
      e = (c == int'(LAT));
      chk($sformatf("postrst_c%0d", c), {31'd0, hit}, {31'd0, e});
    end
    chk("postrst_idx", {30'd0, hit_idx}, 32'd2);
    run(20, p);
    chk("postrst_once", p, 32'd0);
    btn = 4'b0000;
    run(20, p);
    chk("postrst_settle", p, 32'd0);

    // Drop game_en mid-debounce: the event is lost, even after re-enable.
    btn = 4'b0100;
    tick(); tick(); tick();
    game_en = 1'b0;
    run(15, p);
    chk("dis_nopulse", p, 32'd0);
    chk("dis_out", {27'd0, hit, miss, whack_clear}, 32'd0);
    game_en = 1'b1;
    run(10, p);
    chk("reen_nopulse", p, 32'd0);
    btn = 4'b0000;
    run(12, p);
    chk("reen_settle", p, 32'd0);
    press_expect("reen_hit", 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule
